// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin arbiter sharing one 4-operand+carry adder among NREQ requesters.
// Define ADDER_RR_SCHED_STATS_EN to add the saturating op_count completed-operation counter.
module adder_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int SW   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*(4*W+1)-1:0]   req_ops,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [SW-1:0]             rsp_sum,
    output logic                      rsp_zero,
`ifdef ADDER_RR_SCHED_STATS_EN
    output logic [15:0]               op_count,
`endif
    output logic [1:0]                dbg_state_o
);
    localparam int IDW = $clog2(NREQ);
    localparam int BW  = 4*W+1;
    localparam int AW  = (SW > W+3) ? SW : W+3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic [BW-1:0]    ops_q, ops_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic             zero_q, zero_d;
    logic [SW-1:0]    sum_trunc;
    logic             accept;
    logic             rsp_fire;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is a one-cycle grant offer and may go away if the requester drops valid;
    // rsp_valid stays high with a stable payload until rsp_ready is seen.

    // Search rr_ptr, rr_ptr+1, ... wrapping at NREQ-1 so unused ids are never visited.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    assign accept   = (state_q == S_IDLE) && gnt_found;
    assign rsp_fire = (state_q == S_RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)   state_d = S_CALC;
            S_CALC:                state_d = S_RESP;
            S_RESP:  if (rsp_fire) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept && !rst) req_ready[gnt_idx] = 1'b1;
        rsp_valid   = (state_q == S_RESP);
        rsp_id      = id_q;
        rsp_sum     = sum_q;
        rsp_zero    = zero_q;
        dbg_state_o = state_q;
    end

    // Operands widened before summing so the carry chain is exact, then wrapped to SW bits.
    assign sum_trunc = SW'(AW'(ops_q[W-1:0])     + AW'(ops_q[2*W-1:W]) +
                           AW'(ops_q[3*W-1:2*W]) + AW'(ops_q[4*W-1:3*W]) +
                           AW'(ops_q[4*W]));

    always_comb begin
        ops_d    = ops_q;
        id_d     = id_q;
        sum_d    = sum_q;
        zero_d   = zero_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            ops_d = req_ops[int'(gnt_idx)*BW +: BW];
            id_d  = gnt_idx;
        end
        if (state_q == S_CALC) begin
            sum_d  = sum_trunc;
            zero_d = (sum_trunc == '0);
        end
        if (rsp_fire) rr_ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            id_q     <= '0;
            ops_q    <= '0;
            sum_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            ops_q    <= ops_d;
            sum_q    <= sum_d;
            zero_q   <= zero_d;
        end
    end

`ifdef ADDER_RR_SCHED_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rsp_fire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: a default instance (NREQ=4, SW=10) and a
// NREQ=3, SW=8 instance for id wrap and sum wrap-to-zero. op_count checked under ADDER_RR_SCHED_STATS_EN.
module tb_adder_rr_sched;
    logic         clk = 1'b0;
    logic         rst;

    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [131:0] req_ops;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [9:0]   rsp_sum;
    logic         rsp_zero;
    logic [1:0]   dbg_state;

    logic [2:0]   b_req_valid;
    logic [2:0]   b_req_ready;
    logic [98:0]  b_req_ops;
    logic         b_rsp_valid;
    logic         b_rsp_ready;
    logic [1:0]   b_rsp_id;
    logic [7:0]   b_rsp_sum;
    logic         b_rsp_zero;
    logic [1:0]   b_dbg_state;

`ifdef ADDER_RR_SCHED_STATS_EN
    logic [15:0]  op_count;
    logic [15:0]  b_op_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int rr_order [5]  = '{0, 1, 2, 3, 0};
    int rr_sum   [4]  = '{8, 30, 50, 72};
    int b_order  [4]  = '{0, 1, 2, 0};
    int b_sum    [4]  = '{0, 3, 253, 0};
    int b_zero   [4]  = '{1, 0, 0, 1};

    always #5 clk = ~clk;

    adder_rr_sched #(.NREQ(4), .W(8), .SW(10)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ops    (req_ops),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_zero   (rsp_zero),
`ifdef ADDER_RR_SCHED_STATS_EN
        .op_count   (op_count),
`endif
        .dbg_state_o(dbg_state)
    );

    adder_rr_sched #(.NREQ(3), .W(8), .SW(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_ops    (b_req_ops),
        .rsp_valid  (b_rsp_valid),
        .rsp_ready  (b_rsp_ready),
        .rsp_id     (b_rsp_id),
        .rsp_sum    (b_rsp_sum),
        .rsp_zero   (b_rsp_zero),
`ifdef ADDER_RR_SCHED_STATS_EN
        .op_count   (b_op_count),
`endif
        .dbg_state_o(b_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] pack(input logic cin, input logic [7:0] w, input logic [7:0] z,
                                         input logic [7:0] y, input logic [7:0] x);
        return {cin, w, z, y, x};
    endfunction

    task automatic set_ops(input int i, input logic [32:0] b);
        req_ops[i*33 +: 33] = b;
    endtask

    task automatic set_b_ops(input int i, input logic [32:0] b);
        b_req_ops[i*33 +: 33] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 4'hF;
        req_ops     = '0;
        rsp_ready   = 1'b0;
        b_req_valid = 3'b111;
        b_req_ops   = '0;
        b_rsp_ready = 1'b0;

        // Reset held two cycles with every requester valid
        @(negedge clk);
        #1 check("reset_ready_c1", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_b_ready", 32'(b_req_ready), 32'h0);
        check("reset_valid", 32'(rsp_valid), 32'h0);
        check("reset_id", 32'(rsp_id), 32'h0);
        check("reset_sum", 32'(rsp_sum), 32'h0);
        check("reset_zero", 32'(rsp_zero), 32'h0);
        check("reset_state", 32'(dbg_state), 32'h0);
`ifdef ADDER_RR_SCHED_STATS_EN
        check("reset_op_count", 32'(op_count), 32'h0);
`endif
        rst         = 1'b0;
        req_valid   = 4'h0;
        b_req_valid = 3'b000;

        // Single op on requester 0: 4+1+2+3+1 = 11, response two cycles after accept
        @(negedge clk);
        set_ops(0, pack(1'b1, 8'd3, 8'd2, 8'd1, 8'd4));
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1 check("single_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        #1 check("single_calc_valid", 32'(rsp_valid), 32'h0);
        check("single_calc_state", 32'(dbg_state), 32'h1);
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_id", 32'(rsp_id), 32'h0);
        check("single_rsp_sum", 32'(rsp_sum), 32'd11);
        check("single_rsp_zero", 32'(rsp_zero), 32'h0);
        @(negedge clk);
        check("single_after_valid", 32'(rsp_valid), 32'h0);

        // Round robin from rr_ptr=0 with all four valid: slot i sum = 21*i + 8 + (i&1)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            set_ops(i, pack(1'(i & 1), 8'd1, 8'd2, 8'(i), 8'(i*20 + 5)));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1 check("rr_grant", 32'(req_ready), 32'(1 << rr_order[n]));
            @(negedge clk);
            check("rr_calc_ready", 32'(req_ready), 32'h0);
            check("rr_calc_valid", 32'(rsp_valid), 32'h0);
            @(negedge clk);
            check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            check("rr_rsp_ready_off", 32'(req_ready), 32'h0);
            check("rr_rsp_id", 32'(rsp_id), 32'(rr_order[n]));
            check("rr_rsp_sum", 32'(rsp_sum), 32'(rr_sum[rr_order[n]]));
            @(negedge clk);
        end

        // Backpressure: grant 1, hold response six cycles, then one handshake
        rsp_ready = 1'b0;
        #1 check("bp_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        @(negedge clk);
        check("bp_first_valid", 32'(rsp_valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'h1);
            check("bp_hold_id", 32'(rsp_id), 32'h1);
            check("bp_hold_sum", 32'(rsp_sum), 32'd30);
            check("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_after_valid", 32'(rsp_valid), 32'h0);
        #1 check("bp_next_grant", 32'(req_ready), 32'h4);
        req_valid = 4'h0;
        #1 check("drop_valid_ready", 32'(req_ready), 32'h0);

        // Max operands on requester 3: 4*255+1 = 1021 fits in 10 bits
        @(negedge clk);
        set_ops(3, pack(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF));
        req_valid = 4'b1000;
        #1 check("max_grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check("max_rsp_id", 32'(rsp_id), 32'h3);
        check("max_rsp_sum", 32'(rsp_sum), 32'd1021);
        check("max_rsp_zero", 32'(rsp_zero), 32'h0);
        @(negedge clk);

        // All-zero operands on requester 0 set the zero flag
        set_ops(0, pack(1'b0, 8'd0, 8'd0, 8'd0, 8'd0));
        req_valid = 4'b0001;
        #1 check("zero_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check("zero_rsp_sum", 32'(rsp_sum), 32'h0);
        check("zero_rsp_zero", 32'(rsp_zero), 32'h1);
        @(negedge clk);
`ifdef ADDER_RR_SCHED_STATS_EN
        check("op_count_8", 32'(op_count), 32'd8);
`endif

        // Reset during RESP (rr_ptr=1 before): op dropped, rr_ptr back to 0
        req_valid = 4'b1000;
        #1 check("mid_grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check("mid_rsp_valid", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_sum", 32'(rsp_sum), 32'h0);
`ifdef ADDER_RR_SCHED_STATS_EN
        check("mid_rst_op_count", 32'(op_count), 32'h0);
`endif
        rst       = 1'b0;
        req_valid = 4'b0101;
        #1 check("mid_rr_ptr_zero", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;

        // NREQ=3, SW=8: ids wrap 2 -> 0, 4*64 wraps to 0, 1021 mod 256 = 253
        @(negedge clk);
        set_b_ops(0, pack(1'b0, 8'd64, 8'd64, 8'd64, 8'd64));
        set_b_ops(1, pack(1'b0, 8'd0, 8'd0, 8'd1, 8'd2));
        set_b_ops(2, pack(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF));
        b_req_valid = 3'b111;
        b_rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1 check("b_grant", 32'(b_req_ready), 32'(1 << b_order[n]));
            @(negedge clk);
            @(negedge clk);
            check("b_rsp_valid", 32'(b_rsp_valid), 32'h1);
            check("b_rsp_id", 32'(b_rsp_id), 32'(b_order[n]));
            check("b_rsp_sum", 32'(b_rsp_sum), 32'(b_sum[n]));
            check("b_rsp_zero", 32'(b_rsp_zero), 32'(b_zero[n]));
            @(negedge clk);
        end
        b_req_valid = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
